seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan scheduler for the board's 4-digit multiplexed 7-segment display.
//  - Time-shares the single segment bus (Dout) between the four digit enables (ScanEn).
//  - Holds a double-buffered 16-bit hex frame plus decimal points; accepts updates over a req/ack port.
//  - Inserts a blanking gap between digits (anti-ghosting); frame updates land only on frame boundaries.
// PARAMETERS
//  DIV        1000  clocks per digit slot (drive + blank); DIV > BLANK_CYC required
//  BLANK_CYC  16    blank clocks at end of each slot; >= 1
// PORTS
//  FPGA_clk   in   1   system clock
//  clr        in   1   asynchronous, active-low reset
//  Start      in   1   level: 1 = scan enabled, 0 = stop at end of current slot
//  wr_req     in   1   write request for new frame
//  wr_data    in   16  four hex nibbles; [3:0] = digit 0 ... [15:12] = digit 3
//  wr_dp      in   4   decimal point per digit, 1 = lit
//  wr_ack     out  1   one-cycle pulse: write captured
//  ScanEn     out  4   digit enables, active-low, at most one low
//  Dout       out  8   {dp_n, g_n..a_n}, active-low segments
//  frame_tick out  1   one-cycle pulse at each frame boundary
//  Tp         out  1   test point; toggles on every frame_tick
// BEHAVIOUR
//  Reset (clr=0, async): ScanEn=4'hF, Dout=8'hFF, wr_ack=0, frame_tick=0, Tp=0.
//   Also: state=IDLE, idx=0, slot counter=0, shadow/active buffers=0, pending=0.
//   Reset mid-scan blanks outputs immediately.
//  States:
//   IDLE  - outputs blank. Start=1 -> DRIVE with idx=0, cnt=0. If pending, active<=shadow every cycle.
//   DRIVE - ScanEn[idx]=0, all others 1; Dout={~dp[idx], seg7(nib[idx])}.
//           Lasts DIV-BLANK_CYC cycles -> BLANK.
//   BLANK - ScanEn=4'hF, Dout=8'hFF for BLANK_CYC cycles. At end of slot:
//           if idx==3: frame boundary (frame_tick=1, Tp toggles, active<=shadow if pending, pending<=0).
//           Then: Start=0 -> IDLE with idx=0; otherwise idx<=idx+1 mod 4 -> DRIVE.
//  Outputs are registered: first DRIVE cycle appears 1 clk after the state transition decision.
//  Start falling never truncates a slot.
//  Write port:
//   - Capture when wr_req=1 && wr_ack=0: shadow<={wr_dp,wr_data}, pending<=1, wr_ack=1 next cycle.
//   - wr_req held high -> capture on alternate cycles; last write wins.
//  Capture and frame-boundary transfer in the same cycle: active gets the OLD shadow; pending stays 1 (set wins).
//  seg7 encoding (g..a, active-low):
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001  5=0010010  6=0000010  7=1111000
//   8=0000000  9=0010000  A=0001000  b=0000011  C=1000110  d=0100001  E=0000110  F=0001110
//  Slot counter width $clog2(DIV); wraps to 0 at DIV-1. idx is 2 bits.
// STRUCTURE
//  seg_pkg: NDIG=4, state enum {IDLE,DRIVE,BLANK}, seg7 table, SEG_OFF=8'hFF.
//  Sub-module seg7_dec (combinational nibble -> 7 active-low segments), one instance on muxed nibble.
//  Remainder (slot counter, FSM, shadow/active regs, handshake) stays in seg_scan_ctrl.
// TESTING  (DIV=8, BLANK_CYC=2, 100 MHz clock)
//  1 Reset: clr=0 -> ScanEn=4'hF, Dout=8'hFF, Tp=0. Hold Start=1 under reset -> outputs stay blank.
//  2 Scan order: write 16'h3210, dp=4'b0000, then Start=1. Required digit 0 sequence:
//     6 clks ScanEn=1110/Dout=8'hC0, then 2 clks 4'hF/8'hFF.
//    Digits 1..3 follow: ScanEn 1101/F9, 1011/A4, 0111/B0. frame_tick pulses after slot 3 blank; Tp toggles.
//  3 Frame-atomic update: write 16'hFFFF mid-digit-1 -> digits 1..3 keep old values this frame.
//    Digit 0 of next frame shows 8'h8E; wr_ack is one pulse 1 clk after wr_req.
//  4 Collision: wr_req asserted so capture coincides with frame boundary -> next frame shows previous shadow.
//    Following frame shows new data.
//  5 Stop: drop Start during digit 2 DRIVE -> digit 2 completes its 6+2 cycles, then IDLE blank.
//    Restart -> resumes at digit 0.
//  6 Async reset mid-DRIVE: clr low between clock edges -> ScanEn=4'hF same time step; pending cleared.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : seg_scan_ctrl_pkg                                               |
// | Purpose  : Shared types and constants for the 4-digit 7-segment scanner:   |
// |            digit count, scan FSM states, frame buffer layout and the       |
// |            hex-to-segment table (active-low, bit order g..a).             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seg_scan_ctrl_pkg;

  localparam int NDIG = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  // One displayable frame: a decimal point and a hex nibble per digit.
  typedef struct packed {
    logic [NDIG-1:0]   dp;
    logic [4*NDIG-1:0] data;
  } frame_t;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg_n;
    case (nib)
      4'h0:    seg_n = 7'b1000000;
      4'h1:    seg_n = 7'b1111001;
      4'h2:    seg_n = 7'b0100100;
      4'h3:    seg_n = 7'b0110000;
      4'h4:    seg_n = 7'b0011001;
      4'h5:    seg_n = 7'b0010010;
      4'h6:    seg_n = 7'b0000010;
      4'h7:    seg_n = 7'b1111000;
      4'h8:    seg_n = 7'b0000000;
      4'h9:    seg_n = 7'b0010000;
      4'hA:    seg_n = 7'b0001000;
      4'hB:    seg_n = 7'b0000011;
      4'hC:    seg_n = 7'b1000110;
      4'hD:    seg_n = 7'b0100001;
      4'hE:    seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
    return seg_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: seg_scan_ctrl_if                                                |
// | Purpose  : Frame write port of the display scanner (req/ack handshake).    |
// |   wr_req  : request to load a new frame                                    |
// |   wr_data : four hex nibbles, [3:0] = digit 0 ... [15:12] = digit 3        |
// |   wr_dp   : decimal point per digit, 1 = lit                               |
// |   wr_ack  : one-cycle pulse, frame captured into the shadow buffer         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seg_scan_ctrl_if;
  import seg_scan_ctrl_pkg::*;

  logic              wr_req;
  logic [4*NDIG-1:0] wr_data;
  logic [NDIG-1:0]   wr_dp;
  logic              wr_ack;

  modport master (output wr_req, output wr_data, output wr_dp, input  wr_ack);
  modport slave  (input  wr_req, input  wr_data, input  wr_dp, output wr_ack);

endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl_seg7_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_dec                                                        |
// | Purpose  : Combinational hex nibble to active-low 7-segment decoder.       |
// |   nib    : in  4  hex value                                                |
// |   seg_n  : out 7  segments g..a, 0 = lit                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_dec
  import seg_scan_ctrl_pkg::*;
(
  input  wire logic [3:0] nib,
  output logic      [6:0] seg_n
);

  assign seg_n = seg7(nib);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                                   |
// | Purpose  : Scan scheduler for a 4-digit multiplexed 7-segment display.     |
// |            Each digit slot is DIV clocks: DIV-BLANK_CYC driving, then      |
// |            BLANK_CYC blanked. Frames are double-buffered; a written frame  |
// |            becomes visible only at a frame boundary (or while idle).       |
// |   FPGA_clk   : in   system clock                                           |
// |   clr        : in   asynchronous active-low reset                          |
// |   Start      : in   1 = scan, 0 = stop at end of the current slot          |
// |   bus        : slave write port (wr_req/wr_data/wr_dp/wr_ack)              |
// |   ScanEn     : out  4 digit enables, active-low                            |
// |   Dout       : out  8 {dp_n, g_n..a_n}, active-low                         |
// |   frame_tick : out  one-cycle pulse per frame boundary                     |
// |   Tp         : out  toggles on every frame_tick                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 16
) (
  input  wire logic            FPGA_clk,
  input  wire logic            clr,
  input  wire logic            Start,
  seg_scan_ctrl_if.slave       bus,
  output logic      [NDIG-1:0] ScanEn,
  output logic      [7:0]      Dout,
  output logic                 frame_tick,
  output logic                 Tp
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] c_drv_last  = CNT_W'(DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(DIV - 1);

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [CNT_W-1:0]  r_cnt;
  frame_t            r_shadow;
  frame_t            r_active;
  logic              r_pending;
  logic              r_wr_ack;
  logic [NDIG-1:0]   r_scan_en;
  logic [7:0]        r_dout;
  logic              r_frame_tick;
  logic              r_tp;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_capture;
  logic [1:0]        w_idx_nxt;
  frame_t            w_active_nxt;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg_n;

  // The registered outputs are loaded from next-cycle values, so the decoder
  // looks at the digit index and frame that will be current after this edge.
  // That way the first digit of a new frame already shows the new data.
  always_comb begin
    w_slot_end   = (r_state == BLANK) && (r_cnt == c_slot_last);
    w_frame_end  = w_slot_end && (r_idx == 2'd3);
    w_capture    = bus.wr_req && !r_wr_ack;

    w_active_nxt = r_active;
    if (r_pending && ((r_state == IDLE) || w_frame_end)) begin
      w_active_nxt = r_shadow;
    end

    w_idx_nxt = r_idx;
    if (r_state == IDLE) begin
      w_idx_nxt = 2'd0;
    end else if (w_slot_end) begin
      w_idx_nxt = Start ? (r_idx + 2'd1) : 2'd0;
    end

    w_nib = w_active_nxt.data[{w_idx_nxt, 2'b00} +: 4];
  end

  seg7_dec u_seg7_dec (
    .nib   (w_nib),
    .seg_n (w_seg_n)
  );

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_scan_en    <= '1;
      r_dout       <= SEG_OFF;
      r_frame_tick <= 1'b0;
      r_tp         <= 1'b0;
    end else begin
      r_active     <= w_active_nxt;
      r_idx        <= w_idx_nxt;
      r_wr_ack     <= 1'b0;
      r_frame_tick <= 1'b0;

      if (w_frame_end) begin
        r_pending    <= 1'b0;
        r_frame_tick <= 1'b1;
        r_tp         <= ~r_tp;
      end

      // Placed after the frame-boundary clear: a write landing on the
      // boundary keeps pending set so it is shown on the following frame.
      if (w_capture) begin
        r_shadow  <= '{dp: bus.wr_dp, data: bus.wr_data};
        r_pending <= 1'b1;
        r_wr_ack  <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state   <= DRIVE;
            r_cnt     <= '0;
            r_scan_en <= ~(NDIG'(1) << w_idx_nxt);
            r_dout    <= {~w_active_nxt.dp[w_idx_nxt], w_seg_n};
          end else begin
            r_scan_en <= '1;
            r_dout    <= SEG_OFF;
          end
        end
        DRIVE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_drv_last) begin
            r_state   <= BLANK;
            r_scan_en <= '1;
            r_dout    <= SEG_OFF;
          end
        end
        BLANK: begin
          if (w_slot_end) begin
            r_cnt <= '0;
            if (Start) begin
              r_state   <= DRIVE;
              r_scan_en <= ~(NDIG'(1) << w_idx_nxt);
              r_dout    <= {~w_active_nxt.dp[w_idx_nxt], w_seg_n};
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_scan_en <= '1;
          r_dout    <= SEG_OFF;
        end
      endcase
    end
  end

  assign bus.wr_ack = r_wr_ack;
  assign ScanEn     = r_scan_en;
  assign Dout       = r_dout;
  assign frame_tick = r_frame_tick;
  assign Tp         = r_tp;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg_scan_ctrl                                                |
// | Purpose  : Directed self-checking bench for seg_scan_ctrl with DIV=8,      |
// |            BLANK_CYC=2 (6 drive + 2 blank clocks per digit), 100 MHz.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] scan_en;
  logic [7:0] dout;
  logic       frame_tick;
  logic       tp;

  int   total = 0;
  int   bad   = 0;
  logic tp_exp;
  int   pend_ack = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.DIV(8), .BLANK_CYC(2)) dut (
    .FPGA_clk   (clk),
    .clr        (clr),
    .Start      (start),
    .bus        (bus),
    .ScanEn     (scan_en),
    .Dout       (dout),
    .frame_tick (frame_tick),
    .Tp         (tp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Follows up a write issued on an earlier sample point: ack one cycle
  // after the request, gone on the cycle after that.
  task automatic ack_track();
    if (pend_ack == 1) begin
      check("wr_ack_pulse", 32'(bus.wr_ack), 32'd1);
      bus.wr_req = 1'b0;
      pend_ack   = 2;
    end else if (pend_ack == 2) begin
      check("wr_ack_drop", 32'(bus.wr_ack), 32'd0);
      pend_ack = 0;
    end
  endtask

  // One digit slot: 6 driven samples then 2 blank samples. Optionally
  // issues a write (wr_at) or drops Start (stop_at) after sample i.
  task automatic run_slot(input string tag, input logic [3:0] en, input logic [7:0] seg,
                          input logic ft, input int wr_at, input int stop_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ack_track();
      if (i == 0) begin
        if (ft) tp_exp = ~tp_exp;
        check({tag, "_tick"}, 32'(frame_tick), 32'(ft));
        check({tag, "_tp"}, 32'(tp), 32'(tp_exp));
      end
      if (i == 1) check({tag, "_tick_off"}, 32'(frame_tick), 32'd0);
      if (i < 6) check(tag, 32'({scan_en, dout}), 32'({en, seg}));
      else       check({tag, "_blank"}, 32'({scan_en, dout}), 32'h0000_0FFF);
      if (i == wr_at) begin
        bus.wr_req = 1'b1;
        pend_ack   = 1;
      end
      if (i == stop_at) start = 1'b0;
    end
  endtask

  initial begin
    clr         = 1'b0;
    start       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.wr_data = 16'h0000;
    bus.wr_dp   = 4'b0000;
    tp_exp      = 1'b0;

    // Reset held with Start=1: everything stays blank
    repeat (3) @(negedge clk);
    check("rst_scan_en", 32'(scan_en), 32'h0000_000F);
    check("rst_dout", 32'(dout), 32'h0000_00FF);
    check("rst_tp", 32'(tp), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_ack", 32'(bus.wr_ack), 32'd0);
    start = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    check("idle_blank", 32'({scan_en, dout}), 32'h0000_0FFF);

    // Load 3210 while idle, then start scanning
    bus.wr_data = 16'h3210;
    bus.wr_req  = 1'b1;
    @(negedge clk);
    check("first_ack", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("first_ack_drop", 32'(bus.wr_ack), 32'd0);
    start = 1'b1;
    run_slot("f1d0", 4'hE, 8'hC0, 1'b0, -1, -1);
    run_slot("f1d1", 4'hD, 8'hF9, 1'b0, -1, -1);
    run_slot("f1d2", 4'hB, 8'hA4, 1'b0, -1, -1);
    run_slot("f1d3", 4'h7, 8'hB0, 1'b0, -1, -1);

    // FFFF written during digit 1: this frame keeps the old digits
    bus.wr_data = 16'hFFFF;
    run_slot("f2d0", 4'hE, 8'hC0, 1'b1, -1, -1);
    run_slot("f2d1", 4'hD, 8'hF9, 1'b0, 1, -1);
    run_slot("f2d2", 4'hB, 8'hA4, 1'b0, -1, -1);
    run_slot("f2d3", 4'h7, 8'hB0, 1'b0, -1, -1);

    // Write E4C9 mid-frame, then 7DB6 (dp 1010) landing on the boundary
    bus.wr_data = 16'hE4C9;
    run_slot("f3d0", 4'hE, 8'h8E, 1'b1, -1, -1);
    run_slot("f3d1", 4'hD, 8'h8E, 1'b0, 1, -1);
    run_slot("f3d2", 4'hB, 8'h8E, 1'b0, -1, -1);
    bus.wr_data = 16'h7DB6;
    bus.wr_dp   = 4'b1010;
    run_slot("f3d3", 4'h7, 8'h8E, 1'b0, 7, -1);

    // Collision frame shows the previous shadow (E4C9)
    run_slot("f4d0", 4'hE, 8'h90, 1'b1, -1, -1);
    run_slot("f4d1", 4'hD, 8'hC6, 1'b0, -1, -1);
    run_slot("f4d2", 4'hB, 8'h99, 1'b0, -1, -1);
    run_slot("f4d3", 4'h7, 8'h86, 1'b0, -1, -1);

    // Following frame shows 7DB6 with decimal points on digits 1 and 3
    run_slot("f5d0", 4'hE, 8'h82, 1'b1, -1, -1);
    run_slot("f5d1", 4'hD, 8'h03, 1'b0, -1, -1);
    run_slot("f5d2", 4'hB, 8'hA1, 1'b0, -1, -1);
    run_slot("f5d3", 4'h7, 8'h78, 1'b0, -1, -1);

    // Drop Start during digit 2 drive: slot completes, then idle
    run_slot("f6d0", 4'hE, 8'h82, 1'b1, -1, -1);
    run_slot("f6d1", 4'hD, 8'h03, 1'b0, -1, -1);
    run_slot("f6d2", 4'hB, 8'hA1, 1'b0, -1, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stop_idle", 32'({scan_en, dout}), 32'h0000_0FFF);
      check("stop_tick", 32'(frame_tick), 32'd0);
    end
    start = 1'b1;
    run_slot("rs_d0", 4'hE, 8'h82, 1'b0, -1, -1);
    @(negedge clk);
    check("rs_d1", 32'({scan_en, dout}), 32'h0000_0D03);

    // Asynchronous reset between clock edges
    #2;
    clr = 1'b0;
    #1;
    check("async_scan_en", 32'(scan_en), 32'h0000_000F);
    check("async_dout", 32'(dout), 32'h0000_00FF);
    check("async_tp", 32'(tp), 32'd0);
    tp_exp = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    clr = 1'b1;

    // wr_req held high: capture on alternate cycles, last write wins
    bus.wr_data = 16'h0001;
    bus.wr_dp   = 4'b0000;
    bus.wr_req  = 1'b1;
    @(negedge clk);
    check("hold_ack0", 32'(bus.wr_ack), 32'd1);
    bus.wr_data = 16'h0002;
    @(negedge clk);
    check("hold_ack1", 32'(bus.wr_ack), 32'd0);
    @(negedge clk);
    check("hold_ack2", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("hold_ack3", 32'(bus.wr_ack), 32'd0);
    start = 1'b1;
    run_slot("post_d0", 4'hE, 8'hA4, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
